multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
- Multicycle main control FSM for the 4-bit CPU; sits directly upstream of aludec.
- Takes the instruction opcode from the instruction register and sequences fetch/decode/execute/memory/writeback.
- Drives the datapath enables and mux selects, and the 2-bit aluop that aludec combines with op to form alucontrol.
- Handshakes with instruction/data memory through mem_ready.

Parameters:
- STATE_W, 4, width of the state register and the state debug output.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- op  in  4  opcode from instruction register; also routed unchanged to aludec
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- pc_en  out  1  PC load enable, = pcwrite | (branch & zero)
- irwrite  out  1  instruction register load
- regwrite  out  1  register file write
- memwrite  out  1  data memory write request
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- alusrca  out  1  ALU A select: 0 = PC, 1 = regA
- alusrcb  out  2  ALU B select: 00 = regB, 01 = const 1, 10 = sign-extended imm, 11 = branch offset
- pcsrc  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- memtoreg  out  1  writeback source: 1 = memory data
- regdst  out  1  destination register select: 1 = rd field
- aluop  out  2  00 = add, 01 = subtract, 10 = decode from op (consumed by aludec)
- illegal  out  1  one-cycle pulse on an undefined opcode
- halted  out  1  high while in HALT
- state  out  STATE_W  current state, for debug

Behaviour:
- Opcode map:
  - 0000-0111: R-type.
  - 1000: ADDI.
  - 1010: LW.
  - 1100: SW.
  - 1101: BEQ.
  - 1110: JMP.
  - 1111: HALT.
  - 1001, 1011: illegal.
- State register and reset:
  - State register updates on posedge clk.
  - reset=1 forces next state to FETCH.
  - In any cycle with reset=1, all outputs are 0 (write enables and selects), illegal=0, halted=0.
  - Reset mid-operation aborts the instruction with no further writes.
- Output timing:
  - Outputs are decoded from the state register (Moore).
  - Exception: irwrite, pc_en and the stall rules below also depend on mem_ready/zero in the same cycle.
  - Any output not listed for a state is 0.
- FETCH:
  - iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00.
  - irwrite=pcwrite=mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE:
  - alusrca=0, alusrcb=11, aluop=00 (precomputes the branch target into ALUOut).
  - Next state: R-type -> EXEC; ADDI -> ADDIEX; LW/SW -> MEMADR; BEQ -> BRANCH; JMP -> JUMP; HALT -> HALT.
  - Illegal opcode: illegal=1 for this cycle, next state FETCH.
- MEMADR: alusrca=1, alusrcb=10, aluop=00. LW -> MEMRD, SW -> MEMWR.
- MEMRD: iord=1; stall until mem_ready=1, then MEMWB.
- MEMWB: regwrite=1, memtoreg=1, regdst=0, then FETCH.
- MEMWR:
  - iord=1, memwrite=1, held every cycle until mem_ready=1, then FETCH.
  - The memory commits the write exactly once, in the mem_ready cycle.
- EXEC: alusrca=1, alusrcb=00, aluop=10, then ALUWB.
- ALUWB: regwrite=1, regdst=1, memtoreg=0, then FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00, then ADDIWB.
- ADDIWB: regwrite=1, regdst=0, memtoreg=0, then FETCH.
- BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1 (so pc_en=zero), then FETCH.
- JUMP: pcsrc=10, pc_en=1, then FETCH.
- HALT: halted=1, all enables 0; stays in HALT until reset. op/mem_ready are ignored.
- Cycle counts with mem_ready tied high:
  - R-type: 4.
  - ADDI: 4.
  - LW: 5.
  - SW: 4.
  - BEQ: 3.
  - JMP: 3.
- Each wait cycle on mem_ready adds one cycle in FETCH/MEMRD/MEMWR.
- The state encoding never reaches an unused code. Should it occur, next state is FETCH and all outputs are 0.

Decomposition:
- Shared package (cpu_pkg):
  - state enum (13 states, STATE_W bits);
  - opcode localparams;
  - aluop codes ALUOP_ADD/SUB/FUNCT;
  - alusrcb and pcsrc select encodings.
- aludec imports the same aluop and opcode constants.
- One sub-module is natural: mctrl_outdec, a combinational state-to-control-word decoder. The FSM (next-state logic and state register) stays in multicycle_ctrl.

Test Plan:
- reset=1 for 2 cycles, then release with mem_ready=1, op=0001 -> FETCH(irwrite=1,pc_en=1), DECODE, EXEC(aluop=10,alusrca=1), ALUWB(regwrite=1,regdst=1), back to FETCH on cycle 5.
- op=1010, mem_ready low for 3 cycles in MEMRD -> state held in MEMRD for 3 cycles, no regwrite; then MEMWB with regwrite=1,memtoreg=1; total 8 cycles.
- op=1100, mem_ready=0 for 2 cycles then 1 -> memwrite=1 and iord=1 for 3 consecutive cycles; return to FETCH; regwrite never asserted.
- op=1101 with zero=1 -> pc_en=1,pcsrc=01,aluop=01 in BRANCH; repeat with zero=0 -> pc_en=0 in BRANCH.
- op=1011 -> illegal=1 for exactly the DECODE cycle, then FETCH, no writes. op=1111 -> halted=1 held 10+ cycles with toggling mem_ready; reset -> FETCH, halted=0.
- Assert reset during MEMWR with memwrite=1 -> memwrite=0 in the same cycle, state=FETCH on the next edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// +------------------------------------------------------------------+
// | cpu_pkg: shared states, opcodes and control encodings             |
// | Revision: 1.0 - initial release                                   |
// +------------------------------------------------------------------+
`default_nettype none

package cpu_pkg;

  localparam int CTRL_STATE_W = 4;

  typedef enum logic [CTRL_STATE_W-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_ADDIEX = 4'd8,
    S_ADDIWB = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_HALT   = 4'd12
  } state_e;

  localparam logic [3:0] OP_ADDI = 4'b1000;
  localparam logic [3:0] OP_LW   = 4'b1010;
  localparam logic [3:0] OP_SW   = 4'b1100;
  localparam logic [3:0] OP_BEQ  = 4'b1101;
  localparam logic [3:0] OP_JMP  = 4'b1110;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       irwrite;
    logic       regwrite;
    logic       memwrite;
    logic       iord;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       memtoreg;
    logic       regdst;
    logic [1:0] aluop;
    logic       illegal;
    logic       halted;
  } ctrl_t;

  function automatic logic is_rtype(input logic [3:0] op);
    return ~op[3];
  endfunction

  function automatic logic is_illegal(input logic [3:0] op);
    return (op == 4'b1001) || (op == 4'b1011);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mctrl_outdec.sv
// +------------------------------------------------------------------+
// | mctrl_outdec: state to datapath control word decoder              |
// | Revision: 1.0 - initial release                                   |
// +------------------------------------------------------------------+
`default_nettype none

module mctrl_outdec
  import cpu_pkg::*;
(
  input  state_e     state_i,
  input  logic [3:0] op_i,
  input  logic       mem_ready_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    unique case (state_i)
      S_FETCH: begin
        ctrl_o.alusrcb = SRCB_ONE;
        ctrl_o.aluop   = ALUOP_ADD;
        ctrl_o.pcsrc   = PCSRC_ALU;
        ctrl_o.irwrite = mem_ready_i;
        ctrl_o.pcwrite = mem_ready_i;
      end
      S_DECODE: begin
        ctrl_o.alusrcb = SRCB_BOFF;
        ctrl_o.aluop   = ALUOP_ADD;
        ctrl_o.illegal = is_illegal(op_i);
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = SRCB_IMM;
        ctrl_o.aluop   = ALUOP_ADD;
      end
      S_MEMRD: ctrl_o.iord = 1'b1;
      S_MEMWB: begin
        ctrl_o.regwrite = 1'b1;
        ctrl_o.memtoreg = 1'b1;
      end
      // Write request is held until the memory accepts it.
      S_MEMWR: begin
        ctrl_o.iord     = 1'b1;
        ctrl_o.memwrite = 1'b1;
      end
      S_EXEC: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = SRCB_REGB;
        ctrl_o.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl_o.regwrite = 1'b1;
        ctrl_o.regdst   = 1'b1;
      end
      S_ADDIWB: ctrl_o.regwrite = 1'b1;
      S_BRANCH: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = SRCB_REGB;
        ctrl_o.aluop   = ALUOP_SUB;
        ctrl_o.pcsrc   = PCSRC_ALUOUT;
        ctrl_o.branch  = 1'b1;
      end
      S_JUMP: begin
        ctrl_o.pcsrc   = PCSRC_JUMP;
        ctrl_o.pcwrite = 1'b1;
      end
      S_HALT:  ctrl_o.halted = 1'b1;
      default: ctrl_o = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// +------------------------------------------------------------------+
// | multicycle_ctrl: main control FSM of the multicycle 4-bit CPU     |
// | Revision: 1.0 - initial release                                   |
// +------------------------------------------------------------------+
`default_nettype none

module multicycle_ctrl
  import cpu_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         op,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_en,
  output logic               irwrite,
  output logic               regwrite,
  output logic               memwrite,
  output logic               iord,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic               memtoreg,
  output logic               regdst,
  output logic [1:0]         aluop,
  output logic               illegal,
  output logic               halted,
  output logic [STATE_W-1:0] state
);

  state_e state_q, state_d;
  ctrl_t  dec_ctrl, ctrl;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    unique case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (is_rtype(op)) state_d = S_EXEC;
        else begin
          unique case (op)
            OP_ADDI:       state_d = S_ADDIEX;
            OP_LW, OP_SW:  state_d = S_MEMADR;
            OP_BEQ:        state_d = S_BRANCH;
            OP_JMP:        state_d = S_JUMP;
            OP_HALT:       state_d = S_HALT;
            default:       state_d = S_FETCH;
          endcase
        end
      end
      S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  mctrl_outdec u_outdec (
    .state_i     (state_q),
    .op_i        (op),
    .mem_ready_i (mem_ready),
    .ctrl_o      (dec_ctrl)
  );

  // Reset silences every control line in the same cycle it is asserted.
  assign ctrl     = reset ? '0 : dec_ctrl;

  assign pc_en    = ctrl.pcwrite | (ctrl.branch & zero);
  assign irwrite  = ctrl.irwrite;
  assign regwrite = ctrl.regwrite;
  assign memwrite = ctrl.memwrite;
  assign iord     = ctrl.iord;
  assign alusrca  = ctrl.alusrca;
  assign alusrcb  = ctrl.alusrcb;
  assign pcsrc    = ctrl.pcsrc;
  assign memtoreg = ctrl.memtoreg;
  assign regdst   = ctrl.regdst;
  assign aluop    = ctrl.aluop;
  assign illegal  = ctrl.illegal;
  assign halted   = ctrl.halted;
  assign state    = STATE_W'(state_q);

endmodule

`default_nettype wire
